uart_tx_param: RTL and testbench

Parametrised UART transmitter: the next-generation serial TX for the FPGA UART path. It replaces the fixed 8N1 transmitter with configurable data width, parity mode and stop-bit count, plus a valid/ready handshake so upstream logic never drops a byte. It sits between the byte source (loopback receiver, command FSM or FIFO) and the `tx` pin.

---
 rtl/uart_tx_param_pkg.sv | 30 +++
 rtl/uart_tx_param_if.sv | 15 +
 rtl/uart_tx_param_baud_gen.sv | 42 ++++
 rtl/uart_tx_param.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_param_pkg.sv
// Shared UART definitions: transmitter state encoding, parity mode
// constants and the parity helper. The parametrised receiver will use
// this package too.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Parity bit over up to 9 payload bits. Unused high bits must be zero;
    // zero-extension does not change the XOR reduction.
    function automatic logic parity_bit(input logic [8:0] d, input int mode);
        logic p;
        if (mode == PAR_ODD) begin
            p = ~^d;
        end else begin
            p = ^d;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between the byte source and the transmitter.
//   data  : payload word, DATA_BITS wide
//   valid : source has a word
//   ready : transmitter accepts a word this cycle
// master = byte source, slave = transmitter.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/uart_tx_param_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   clear : restart the count at 0 (pulsed when a word is accepted)
//   tick  : one-cycle pulse while the count sits at DIV-1
module uart_baud_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int          CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at DIV-1 so every bit lasts exactly DIV cycles.
    always_comb begin
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input handshake.
//   clk  : system clock
//   rst  : asynchronous active-low reset; forces tx high and aborts a frame
//   s_if : word handshake (data/valid in, ready out); ready only in IDLE
//   tx   : serial line, idle high, LSB first
//   busy : frame in progress
// Frame: start, DATA_BITS data, optional parity, STOP_BITS stop bits,
// each DIV = CLK_FREQ/BAUD_RATE cycles. All outputs are registered.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_param_if.slave  s_if,
    output logic            tx,
    output logic            busy
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int IW  = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (DIV < 4) begin : g_bad_div
        $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q,   idx_d;
    logic                 stop_q,  stop_d;
    logic                 par_q,   par_d;
    logic                 tx_q,    tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q,  busy_d;
    logic                 clear_s;
    logic                 tick_s;
    logic                 accept_s;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // ready_q is only ever high in IDLE, so valid elsewhere is ignored.
    assign accept_s = ready_q & s_if.valid;

    // Next-state, datapath and output computation.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        clear_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shift_d = s_if.data;
                    par_d   = parity_bit(9'(s_if.data), PARITY);
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    clear_s = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PAR: begin
                if (tick_s) begin
                    state_d = STOP;
                end else begin
                    state_d = PAR;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_d  = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in
        // step with it: tx falls on the same edge that accepts the word.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PAR:     tx_d = par_q;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // FSM, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign s_if.ready = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param. Three instances share clk/rst:
//   A: DIV=10, 8 data bits, no parity, 1 stop  (F=100)
//   B: DIV=10, 7 data bits, even parity, 2 stop (F=110)
//   C: DIV=10, 9 data bits, odd parity, 1 stop  (F=120)
module tb_uart_tx_param;

    localparam int DIV = 10;

    logic clk;
    logic rst;
    logic tx_a, tx_b, tx_c;
    logic busy_a, busy_b, busy_c;

    int n_cmp;
    int n_bad;

    logic exp_q[$];

    typedef struct {
        int         cfg;
        logic [8:0] data;
        logic       exp_par;
    } vec_t;

    vec_t vecs[7];

    uart_tx_param_if #(.DATA_BITS(8)) if_a ();
    uart_tx_param_if #(.DATA_BITS(7)) if_b ();
    uart_tx_param_if #(.DATA_BITS(9)) if_c ();

    uart_tx_param #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (.clk(clk), .rst(rst), .s_if(if_a.slave), .tx(tx_a), .busy(busy_a));

    uart_tx_param #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) dut_b (.clk(clk), .rst(rst), .s_if(if_b.slave), .tx(tx_b), .busy(busy_b));

    uart_tx_param #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)
    ) dut_c (.clk(clk), .rst(rst), .s_if(if_c.slave), .tx(tx_c), .busy(busy_c));

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cfg_nbits(input int cfg);
        case (cfg)
            0:       return 8;
            1:       return 7;
            default: return 9;
        endcase
    endfunction

    function automatic int cfg_par(input int cfg);
        return (cfg == 0) ? 0 : 1;
    endfunction

    function automatic int cfg_stops(input int cfg);
        return (cfg == 1) ? 2 : 1;
    endfunction

    function automatic logic get_tx(input int cfg);
        case (cfg)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic get_ready(input int cfg);
        case (cfg)
            0:       return if_a.ready;
            1:       return if_b.ready;
            default: return if_c.ready;
        endcase
    endfunction

    function automatic logic get_busy(input int cfg);
        case (cfg)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic drive(input int cfg, input logic [8:0] d, input logic v);
        case (cfg)
            0:       begin if_a.data = d[7:0]; if_a.valid = v; end
            1:       begin if_b.data = d[6:0]; if_b.valid = v; end
            default: begin if_c.data = d;      if_c.valid = v; end
        endcase
    endtask

    task automatic drive_data(input int cfg, input logic [8:0] d);
        case (cfg)
            0:       if_a.data = d[7:0];
            1:       if_b.data = d[6:0];
            default: if_c.data = d;
        endcase
    endtask

    // Called at #1 after the accept edge. Pushes the expected line level for
    // every cycle of the frame, then pops and compares one per cycle, and
    // finally checks the single idle-high cycle with ready back up.
    task automatic check_frame(input int cfg, input logic [8:0] d, input logic p,
                               input logic [8:0] next_d, input logic change);
        int   f;
        logic e;
        repeat (DIV) exp_q.push_back(1'b0);
        for (int i = 0; i < cfg_nbits(cfg); i++) begin
            repeat (DIV) exp_q.push_back(d[i]);
        end
        if (cfg_par(cfg) != 0) begin
            repeat (DIV) exp_q.push_back(p);
        end
        repeat (DIV * cfg_stops(cfg)) exp_q.push_back(1'b1);
        f = exp_q.size();
        for (int k = 0; k < f; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("tx cfg%0d word%0h cycle%0d", cfg, d, k + 1), 32'(get_tx(cfg)), 32'(e));
            if (k % DIV == DIV / 2) begin
                chk($sformatf("busy_in_frame cfg%0d cycle%0d", cfg, k + 1), 32'(get_busy(cfg)), 32'd1);
                chk($sformatf("ready_in_frame cfg%0d cycle%0d", cfg, k + 1), 32'(get_ready(cfg)), 32'd0);
            end
            if (change && k == f / 2) begin
                drive_data(cfg, next_d);
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("idle_tx cfg%0d", cfg), 32'(get_tx(cfg)), 32'd1);
        chk($sformatf("idle_ready cfg%0d", cfg), 32'(get_ready(cfg)), 32'd1);
        chk($sformatf("idle_busy cfg%0d", cfg), 32'(get_busy(cfg)), 32'd0);
    endtask

    task automatic wait_ready(input int cfg);
        int n;
        n = 0;
        while (get_ready(cfg) !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("wait_ready cfg%0d", cfg), 32'(get_ready(cfg)), 32'd1);
    endtask

    task automatic send(input int cfg, input logic [8:0] d, input logic p);
        wait_ready(cfg);
        drive(cfg, d, 1'b1);
        @(posedge clk);
        #1;
        drive(cfg, d, 1'b0);
        check_frame(cfg, d, p, 9'h000, 1'b0);
    endtask

    // ready and busy must never be high together on any instance.
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_and_busy a", 32'(if_a.ready & busy_a), 32'd0);
            chk("ready_and_busy b", 32'(if_b.ready & busy_b), 32'd0);
            chk("ready_and_busy c", 32'(if_c.ready & busy_c), 32'd0);
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk   = 1'b0;
        rst   = 1'b0;
        drive(0, 9'h000, 1'b0);
        drive(1, 9'h000, 1'b0);
        drive(2, 9'h000, 1'b0);

        vecs[0] = '{cfg: 0, data: 9'h0A5, exp_par: 1'b0};
        vecs[1] = '{cfg: 0, data: 9'h03C, exp_par: 1'b0};
        vecs[2] = '{cfg: 1, data: 9'h041, exp_par: 1'b0};
        vecs[3] = '{cfg: 1, data: 9'h07F, exp_par: 1'b1};
        vecs[4] = '{cfg: 2, data: 9'h1FF, exp_par: 1'b0};
        vecs[5] = '{cfg: 2, data: 9'h000, exp_par: 1'b1};
        vecs[6] = '{cfg: 2, data: 9'h0AA, exp_par: 1'b1};

        // Reset state on every instance.
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("reset_tx cfg%0d", c), 32'(get_tx(c)), 32'd1);
            chk($sformatf("reset_ready cfg%0d", c), 32'(get_ready(c)), 32'd0);
            chk($sformatf("reset_busy cfg%0d", c), 32'(get_busy(c)), 32'd0);
        end

        // valid raised in the cycle reset releases must not be taken.
        drive(0, 9'h0A5, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release_ready", 32'(if_a.ready), 32'd1);
        chk("release_busy", 32'(busy_a), 32'd0);
        chk("release_tx", 32'(tx_a), 32'd1);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].cfg, vecs[i].data, vecs[i].exp_par);
        end

        // valid held for three words; data disturbed mid-frame.
        wait_ready(0);
        drive(0, 9'h001, 1'b1);
        @(posedge clk);
        #1;
        drive_data(0, 9'h0EE);
        check_frame(0, 9'h001, 1'b0, 9'h002, 1'b1);
        @(posedge clk);
        #1;
        drive_data(0, 9'h0DD);
        check_frame(0, 9'h002, 1'b0, 9'h003, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 9'h0CC, 1'b0);
        check_frame(0, 9'h003, 1'b0, 9'h000, 1'b0);
        @(posedge clk);
        #1;
        chk("no_extra_word_tx", 32'(tx_a), 32'd1);
        chk("no_extra_word_busy", 32'(busy_a), 32'd0);

        // Reset in the middle of the data bits of 0x55.
        wait_ready(0);
        drive(0, 9'h055, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 9'h055, 1'b0);
        repeat (25) @(posedge clk);
        #1;
        chk("pre_abort_tx", 32'(tx_a), 32'd0);
        chk("pre_abort_busy", 32'(busy_a), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_tx", 32'(tx_a), 32'd1);
        chk("abort_ready", 32'(if_a.ready), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_hold_tx", 32'(tx_a), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_abort_ready", 32'(if_a.ready), 32'd1);
        chk("post_abort_tx", 32'(tx_a), 32'd1);
        send(0, 9'h033, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
